// File: rtl/axi4_s_bus_wr_fifos_pkg.sv
// Shared types for the AXI4-lite slave write front end.
// The decode window helper is only called when AXI4_S_WR_DECERR_EN is defined.
package axi4_s_wr_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        prot;
    } aw_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } w_t;

    // True when addr falls in [base, base+size), evaluated modulo 2**aw
    // so a window near the top of the address space wraps like the bus does.
    function automatic logic in_window(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input logic [63:0] size,
                                       input int          aw);
        logic [63:0] mask;
        logic [63:0] diff;
        mask = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
        diff = (addr - base) & mask;
        return diff < (size & mask);
    endfunction

endpackage

// File: rtl/axi4_s_bus_wr_fifos_if.sv
// AW/W/B channels plus the paired command / user response port.
// slave is the front end's view, master is the view of whoever drives the bus.
interface axi4_s_bus_wr_fifos_if #(
    parameter int A_W = 32,
    parameter int D_W = 32
);
    logic [A_W-1:0]   awaddr;
    logic [2:0]       awprot;
    logic             awvalid;
    logic             awready;
    logic [D_W-1:0]   wdata;
    logic [D_W/8-1:0] wstrb;
    logic             wvalid;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready;
    logic [A_W-1:0]   cmd_addr;
    logic [D_W-1:0]   cmd_data;
    logic [D_W/8-1:0] cmd_strb;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       rsp_resp;
    logic             rsp_valid;
    logic             rsp_ready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  cmd_ready, rsp_resp, rsp_valid,
        output awready, wready, bresp, bvalid,
        output cmd_addr, cmd_data, cmd_strb, cmd_valid, rsp_ready
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output cmd_ready, rsp_resp, rsp_valid,
        input  awready, wready, bresp, bvalid,
        input  cmd_addr, cmd_data, cmd_strb, cmd_valid, rsp_ready
    );
endinterface

// File: rtl/axi4_s_bus_wr_fifos_tiny_sync_fifo.sv
// Small synchronous FIFO with a combinational head. DEPTH must be a power of 2.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module tiny_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi4_s_bus_wr_fifos.sv
// AXI4-lite slave write front end: buffers AW and W, pairs them into one
// command for the user logic, and returns user responses on B in order with
// at most MAX_OUT writes outstanding.
// Optional feature: AXI4_S_WR_DECERR_EN answers writes outside
// [BASE, BASE+SIZE) locally with DECERR instead of issuing them.
module axi4_s_bus_wr_fifos
    import axi4_s_wr_pkg::*;
#(
    parameter int          A_W     = ADDR_W,
    parameter int          D_W     = DATA_W,
    parameter int          MAX_OUT = 4,
    parameter logic [63:0] BASE    = 64'h0,
    parameter logic [63:0] SIZE    = 64'h1000
) (
    input logic                  clk,
    input logic                  reset,
    axi4_s_bus_wr_fifos_if.slave bus
);
    localparam int S_W   = D_W / 8;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic             aw_push, aw_full, aw_empty;
    logic [A_W+2:0]   aw_head;
    logic [A_W-1:0]   aw_head_addr;
    logic [2:0]       aw_head_prot;
    logic             w_push, w_full, w_empty;
    logic [D_W+S_W-1:0] w_head;
    logic             tag_full, tag_empty, tag_head;
    logic             decerr_hit, join_ok, issue, retire, slot_free, b_free;
    logic [CNT_W-1:0] out_cnt;
    logic             bvalid_q;
    resp_t            bresp_q;
    logic             unused_bits;

    assign aw_push     = bus.awvalid & ~aw_full;
    assign w_push      = bus.wvalid & ~w_full;
    assign bus.awready = ~aw_full;
    assign bus.wready  = ~w_full;

    tiny_sync_fifo #(.W(A_W + 3), .DEPTH(2)) aw_fifo (
        .clk(clk), .reset(reset), .push(aw_push), .din({bus.awaddr, bus.awprot}),
        .pop(issue), .dout(aw_head), .full(aw_full), .empty(aw_empty)
    );

    tiny_sync_fifo #(.W(D_W + S_W), .DEPTH(2)) w_fifo (
        .clk(clk), .reset(reset), .push(w_push), .din({bus.wdata, bus.wstrb}),
        .pop(issue), .dout(w_head), .full(w_full), .empty(w_empty)
    );

    // one bit per transaction in issue order: 1 = answer locally with DECERR
    tiny_sync_fifo #(.W(1), .DEPTH(MAX_OUT)) tag_fifo (
        .clk(clk), .reset(reset), .push(issue), .din(decerr_hit),
        .pop(retire), .dout(tag_head), .full(tag_full), .empty(tag_empty)
    );

    assign aw_head_addr = aw_head[A_W+2:3];
    assign aw_head_prot = aw_head[2:0];

`ifdef AXI4_S_WR_DECERR_EN
    assign decerr_hit = ~in_window(64'(aw_head_addr), BASE, SIZE, A_W);
`else
    assign decerr_hit = 1'b0;
`endif
    // prot is carried through the FIFO but nothing downstream consumes it
    assign unused_bits = ^{aw_head_prot, BASE, SIZE};

    // A retire frees a slot in the same cycle, so a full window can still issue.
    assign b_free        = ~bvalid_q | bus.bready;
    assign retire        = ~tag_empty & b_free & (tag_head | bus.rsp_valid);
    assign bus.rsp_ready = ~tag_empty & ~tag_head & b_free;
    assign slot_free     = ((out_cnt < CNT_W'(MAX_OUT)) & ~tag_full) | retire;
    assign join_ok       = ~aw_empty & ~w_empty & slot_free;
    assign issue         = join_ok & (decerr_hit | bus.cmd_ready);

    assign bus.cmd_valid = join_ok & ~decerr_hit;
    assign bus.cmd_addr  = aw_head_addr;
    assign bus.cmd_data  = w_head[D_W+S_W-1:S_W];
    assign bus.cmd_strb  = w_head[S_W-1:0];

    // outstanding count: issued but not yet moved into the B register
    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt <= '0;
        end else if (issue & ~retire) begin
            out_cnt <= out_cnt + CNT_W'(1);
        end else if (~issue & retire) begin
            out_cnt <= out_cnt - CNT_W'(1);
        end
    end

    // B register: reloads whenever the slot is empty or being consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
        end else if (b_free) begin
            bvalid_q <= retire;
            if (retire) begin
                bresp_q <= tag_head ? DECERR : resp_t'(bus.rsp_resp);
            end
        end
    end

    assign bus.bvalid = bvalid_q;
    assign bus.bresp  = bresp_q;

endmodule

// File: tb/tb_axi4_s_bus_wr_fifos.sv
// Bench for axi4_s_bus_wr_fifos: queue-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
// Scenario 6 only runs when AXI4_S_WR_DECERR_EN is defined.
module tb_axi4_s_bus_wr_fifos;
    import axi4_s_wr_pkg::*;

    localparam int MAX_OUT = 4;
`ifdef AXI4_S_WR_DECERR_EN
    localparam logic [63:0] T_BASE = 64'h1000;
`else
    localparam logic [63:0] T_BASE = 64'h0;
`endif
    localparam logic [63:0] T_SIZE = 64'h1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi4_s_bus_wr_fifos_if #(.A_W(32), .D_W(32)) bus ();

    axi4_s_bus_wr_fifos #(
        .A_W(32), .D_W(32), .MAX_OUT(MAX_OUT), .BASE(T_BASE), .SIZE(T_SIZE)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    aw_t         m_aw[$];
    w_t          m_w[$];
    bit          m_tag[$];
    bit          m_bvalid = 1'b0;
    logic [1:0]  m_bresp  = 2'd0;
    logic [63:0] cmd_log[$];
    logic [1:0]  b_log[$];

    always @(negedge clk) begin
        bit e_awready, e_wready, pair, b_free, htag, retire, room, hit, e_cmd_valid, e_rsp_ready, issue;
        if (armed) begin
            e_awready   = m_aw.size() < 2;
            e_wready    = m_w.size() < 2;
            pair        = (m_aw.size() > 0) && (m_w.size() > 0);
            b_free      = !m_bvalid || bus.bready;
            htag        = (m_tag.size() > 0) ? m_tag[0] : 1'b0;
            retire      = (m_tag.size() > 0) && b_free && (htag || bus.rsp_valid);
            room        = (m_tag.size() < MAX_OUT) || retire;
            hit         = 1'b0;
`ifdef AXI4_S_WR_DECERR_EN
            if (m_aw.size() > 0) hit = (m_aw[0].addr - T_BASE[31:0]) >= T_SIZE[31:0];
`endif
            e_cmd_valid = pair && room && !hit;
            e_rsp_ready = (m_tag.size() > 0) && !htag && b_free;
            issue       = pair && room && (hit || bus.cmd_ready);

            chk("mdl_awready",   64'(bus.awready),   64'(e_awready));
            chk("mdl_wready",    64'(bus.wready),    64'(e_wready));
            chk("mdl_cmd_valid", 64'(bus.cmd_valid), 64'(e_cmd_valid));
            chk("mdl_rsp_ready", 64'(bus.rsp_ready), 64'(e_rsp_ready));
            chk("mdl_bvalid",    64'(bus.bvalid),    64'(m_bvalid));
            chk("mdl_bresp",     64'(bus.bresp),     64'(m_bresp));
            if (e_cmd_valid) begin
                chk("mdl_cmd_addr", 64'(bus.cmd_addr), 64'(m_aw[0].addr));
                chk("mdl_cmd_data", 64'(bus.cmd_data), 64'(m_w[0].data));
                chk("mdl_cmd_strb", 64'(bus.cmd_strb), 64'(m_w[0].strb));
            end

            if (reset) begin
                m_aw.delete();
                m_w.delete();
                m_tag.delete();
                m_bvalid = 1'b0;
                m_bresp  = 2'd0;
            end else begin
                if (m_bvalid && bus.bready) b_log.push_back(m_bresp);
                if (retire) void'(m_tag.pop_front());
                if (b_free) begin
                    m_bvalid = retire;
                    if (retire) m_bresp = htag ? 2'd3 : bus.rsp_resp;
                end
                if (issue) begin
                    if (!hit) cmd_log.push_back({m_aw[0].addr, m_w[0].data});
                    void'(m_aw.pop_front());
                    void'(m_w.pop_front());
                    m_tag.push_back(hit);
                end
                if (bus.awvalid && e_awready) m_aw.push_back('{addr: bus.awaddr, prot: bus.awprot});
                if (bus.wvalid && e_wready)   m_w.push_back('{data: bus.wdata, strb: bus.wstrb});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a);
        bit ok = 1'b0;
        bus.awaddr  = a;
        bus.awprot  = 3'd2;
        bus.awvalid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = bus.awready;
            tick();
        end
        chk("aw_handshake", 64'(ok), 64'd1);
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 1'b0;
        bus.wdata  = d;
        bus.wstrb  = s;
        bus.wvalid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = bus.wready;
            tick();
        end
        chk("w_handshake", 64'(ok), 64'd1);
        bus.wvalid = 1'b0;
    endtask

    task automatic respond(input logic [1:0] code);
        bit ok = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_resp  = code;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = bus.rsp_ready;
            tick();
        end
        chk("rsp_handshake", 64'(ok), 64'd1);
        bus.rsp_valid = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int cb, bb;
        bit seen;
        logic [1:0] codes [5];
        codes = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

        reset = 1'b1;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.cmd_ready = 1'b0;
        bus.rsp_resp = '0; bus.rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        armed = 1'b1;
        @(negedge clk);
        chk("rst_awready",   64'(bus.awready),   64'd1);
        chk("rst_wready",    64'(bus.wready),    64'd1);
        chk("rst_bvalid",    64'(bus.bvalid),    64'd0);
        chk("rst_bresp",     64'(bus.bresp),     64'd0);
        chk("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
        chk("rst_rsp_ready", 64'(bus.rsp_ready), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // 1: single write
        bus.cmd_ready = 1'b1;
        bus.bready    = 1'b1;
        fork
            send_aw(32'h10);
            send_w(32'hDEADBEEF, 4'hF);
        join
        @(negedge clk);
        chk("t1_cmd_valid", 64'(bus.cmd_valid), 64'd1);
        chk("t1_cmd_addr",  64'(bus.cmd_addr),  64'h10);
        chk("t1_cmd_data",  64'(bus.cmd_data),  64'hDEADBEEF);
        chk("t1_cmd_strb",  64'(bus.cmd_strb),  64'hF);
        tick();
        bus.rsp_valid = 1'b1;
        bus.rsp_resp  = 2'd0;
        @(negedge clk);
        chk("t1_rsp_ready", 64'(bus.rsp_ready), 64'd1);
        tick();
        bus.rsp_valid = 1'b0;
        @(negedge clk);
        chk("t1_bvalid", 64'(bus.bvalid), 64'd1);
        chk("t1_bresp",  64'(bus.bresp),  64'd0);
        tick();
        @(negedge clk);
        chk("t1_bvalid_done", 64'(bus.bvalid), 64'd0);
        tick();

        // 2: W before AW
        cb = cmd_log.size();
        send_w(32'hAAAA0001, 4'hF);
        send_w(32'hBBBB0002, 4'h3);
        bus.wdata  = 32'hCCCC0003;
        bus.wvalid = 1'b1;
        @(negedge clk);
        chk("t2_wready_full", 64'(bus.wready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_no_cmd", 64'(bus.cmd_valid), 64'd0);
            tick();
        end
        bus.wvalid = 1'b0;
        send_aw(32'h20);
        send_aw(32'h24);
        repeat (2) tick();
        respond(2'd0);
        respond(2'd0);
        repeat (2) tick();
        chk("t2_cmd_count", 64'(cmd_log.size() - cb), 64'd2);
        chk("t2_cmd0", cmd_log[cb],     {32'h20, 32'hAAAA0001});
        chk("t2_cmd1", cmd_log[cb + 1], {32'h24, 32'hBBBB0002});

        // 3: outstanding cap
        cb = cmd_log.size();
        bb = b_log.size();
        fork
            for (int i = 0; i < 6; i++) send_aw(32'h100 + 32'(4 * i));
            for (int i = 0; i < 6; i++) send_w(32'h5000 + 32'(i), 4'hF);
        join
        repeat (3) tick();
        @(negedge clk);
        chk("t3_cmd_count4", 64'(cmd_log.size() - cb), 64'd4);
        chk("t3_awready",    64'(bus.awready),   64'd0);
        chk("t3_wready",     64'(bus.wready),    64'd0);
        chk("t3_cmd_held",   64'(bus.cmd_valid), 64'd0);
        tick();
        bus.rsp_valid = 1'b1;
        bus.rsp_resp  = 2'd0;
        @(negedge clk);
        chk("t3_retire_rsp_ready", 64'(bus.rsp_ready), 64'd1);
        chk("t3_issue_on_retire",  64'(bus.cmd_valid), 64'd1);
        tick();
        bus.rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) respond(codes[i]);
        repeat (3) tick();
        chk("t3_cmd_count6", 64'(cmd_log.size() - cb), 64'd6);
        chk("t3_cmd5",       cmd_log[cb + 5], {32'h114, 32'h5005});
        chk("t3_b_count",    64'(b_log.size() - bb), 64'd6);
        chk("t3_b1",         64'(b_log[bb + 1]), 64'd1);
        chk("t3_b5",         64'(b_log[bb + 5]), 64'd2);

        // 4: B backpressure
        bb = b_log.size();
        fork
            for (int i = 0; i < 3; i++) send_aw(32'h400 + 32'(4 * i));
            for (int i = 0; i < 3; i++) send_w(32'h7000 + 32'(i), 4'hF);
        join
        repeat (2) tick();
        bus.bready = 1'b0;
        fork
            begin
                respond(2'd2);
                respond(2'd0);
                respond(2'd2);
            end
            begin
                seen = 1'b0;
                for (int n = 0; n < 30 && !seen; n++) begin
                    @(negedge clk);
                    seen = bus.bvalid;
                end
                chk("t4_bvalid_seen", 64'(seen), 64'd1);
                for (int i = 0; i < 4; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("t4_bvalid_hold", 64'(bus.bvalid),    64'd1);
                    chk("t4_bresp_hold",  64'(bus.bresp),     64'd2);
                    chk("t4_rsp_blocked", 64'(bus.rsp_ready), 64'd0);
                end
                tick();
                bus.bready = 1'b1;
            end
        join
        repeat (4) tick();
        chk("t4_b_count", 64'(b_log.size() - bb), 64'd3);
        chk("t4_b0", 64'(b_log[bb]),     64'd2);
        chk("t4_b1", 64'(b_log[bb + 1]), 64'd0);
        chk("t4_b2", 64'(b_log[bb + 2]), 64'd2);

        // 5: reset mid-stream
        bb = b_log.size();
        bus.bready = 1'b0;
        fork
            for (int i = 0; i < 4; i++) send_aw(32'h600 + 32'(4 * i));
            for (int i = 0; i < 4; i++) send_w(32'h8000 + 32'(i), 4'hF);
        join
        repeat (2) tick();
        respond(2'd1);
        send_w(32'h9001, 4'hF);
        send_w(32'h9002, 4'hF);
        @(negedge clk);
        chk("t5_pre_bvalid", 64'(bus.bvalid), 64'd1);
        chk("t5_pre_wready", 64'(bus.wready), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_bvalid",    64'(bus.bvalid),    64'd0);
        chk("t5_cmd_valid", 64'(bus.cmd_valid), 64'd0);
        chk("t5_awready",   64'(bus.awready),   64'd1);
        chk("t5_wready",    64'(bus.wready),    64'd1);
        tick();
        bus.bready = 1'b1;
        fork
            send_aw(32'h300);
            send_w(32'h55AA, 4'h5);
        join
        respond(2'd1);
        repeat (2) tick();
        chk("t5_cmd_after", cmd_log[cmd_log.size() - 1], {32'h300, 32'h55AA});
        chk("t5_b_count",   64'(b_log.size() - bb), 64'd1);
        chk("t5_b0",        64'(b_log[bb]), 64'd1);

`ifdef AXI4_S_WR_DECERR_EN
        // 6: decode window
        cb = cmd_log.size();
        bb = b_log.size();
        bus.cmd_ready = 1'b0;
        fork
            begin
                send_aw(32'h1004);
                send_aw(32'h3000);
                send_aw(32'h1008);
            end
            for (int i = 0; i < 3; i++) send_w(32'hA000 + 32'(i), 4'hF);
            begin
                repeat (3) tick();
                @(negedge clk);
                chk("t6_slow_valid", 64'(bus.cmd_valid), 64'd1);
                chk("t6_slow_addr",  64'(bus.cmd_addr),  64'h1004);
                tick();
                bus.cmd_ready = 1'b1;
            end
        join
        repeat (3) tick();
        respond(2'd0);
        respond(2'd0);
        repeat (4) tick();
        chk("t6_cmd_count", 64'(cmd_log.size() - cb), 64'd2);
        chk("t6_cmd0",      cmd_log[cb],     {32'h1004, 32'hA000});
        chk("t6_cmd1",      cmd_log[cb + 1], {32'h1008, 32'hA002});
        chk("t6_b_count",   64'(b_log.size() - bb), 64'd3);
        chk("t6_b0",        64'(b_log[bb]),     64'd0);
        chk("t6_b1",        64'(b_log[bb + 1]), 64'd3);
        chk("t6_b2",        64'(b_log[bb + 2]), 64'd0);
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
